// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: forward-select
// encodings, register address width and the in-flight scoreboard entry.
package pipe_ctrl_pkg;

   localparam int REG_AW = 5;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              memread;
   } scb_entry_t;

   localparam scb_entry_t SCB_EMPTY = '0;

   // x0 is hardwired zero, so a write to it never produces a forwardable value.
   function automatic logic rd_match(input logic [REG_AW-1:0] rs, input scb_entry_t e);
      return e.valid & e.regwrite & (e.rd != '0) & (e.rd == rs);
   endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// ID-stage instruction fields in, stall/flush/forward controls and counters out.
interface hazard_forward_ctrl_if #(parameter int CNT_W = 32);
   import pipe_ctrl_pkg::*;

   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic [REG_AW-1:0] id_rd;
   logic              id_regwrite;
   logic              id_memread;
   logic              branch_taken;

   logic [1:0]        forwardA;
   logic [1:0]        forwardB;
   logic              pc_write_en;
   logic              ifid_write_en;
   logic              idex_bubble;
   logic              flush_ifid;
   logic [CNT_W-1:0]  stall_count;
   logic [CNT_W-1:0]  flush_count;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, branch_taken,
      input  forwardA, forwardB, pc_write_en, ifid_write_en, idex_bubble, flush_ifid,
             stall_count, flush_count
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, branch_taken,
      output forwardA, forwardB, pc_write_en, ifid_write_en, idex_bubble, flush_ifid,
             stall_count, flush_count
   );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + ONE;
   end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Load-use stall, branch flush and registered EX forward-select generation,
// driven by a scoreboard of the destinations held in ID/EX and EX/MEM.
module hazard_forward_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input logic                 clk,
   input logic                 reset,
   hazard_forward_ctrl_if.slave bus
);

   // Only ID/EX and EX/MEM are tracked: a MEM/WB producer is visible to the
   // consumer in ID through regfile write-through, so it never needs a select.
   scb_entry_t ex_e;
   scb_entry_t mem_e;

   logic       load_use;
   logic       stall;
   logic       flush;
   logic       ex_clear;
   logic [1:0] fwd_a_next;
   logic [1:0] fwd_b_next;
   logic [1:0] fwd_a_q;
   logic [1:0] fwd_b_q;

   always_comb begin
      load_use = bus.id_valid & ex_e.memread &
                 (rd_match(bus.id_rs1, ex_e) | rd_match(bus.id_rs2, ex_e));
      flush    = bus.branch_taken;
      stall    = load_use & ~flush;
      ex_clear = stall | flush | ~bus.id_valid;

      fwd_a_next = FWD_REG;
      if (rd_match(bus.id_rs1, ex_e))
         fwd_a_next = FWD_MEM;
      else if (rd_match(bus.id_rs1, mem_e))
         fwd_a_next = FWD_WB;

      fwd_b_next = FWD_REG;
      if (rd_match(bus.id_rs2, ex_e))
         fwd_b_next = FWD_MEM;
      else if (rd_match(bus.id_rs2, mem_e))
         fwd_b_next = FWD_WB;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_e    <= SCB_EMPTY;
         mem_e   <= SCB_EMPTY;
         fwd_a_q <= FWD_REG;
         fwd_b_q <= FWD_REG;
      end else begin
         mem_e <= ex_e;
         if (ex_clear) begin
            ex_e    <= SCB_EMPTY;
            fwd_a_q <= FWD_REG;
            fwd_b_q <= FWD_REG;
         end else begin
            ex_e.valid    <= 1'b1;
            ex_e.rd       <= bus.id_rd;
            ex_e.regwrite <= bus.id_regwrite;
            ex_e.memread  <= bus.id_memread;
            fwd_a_q       <= fwd_a_next;
            fwd_b_q       <= fwd_b_next;
         end
      end
   end

   // A taken branch must still let the redirected PC and fetch land.
   assign bus.pc_write_en   = ~stall;
   assign bus.ifid_write_en = ~stall;
   assign bus.idex_bubble   = stall | flush;
   assign bus.flush_ifid    = flush;
   assign bus.forwardA      = fwd_a_q;
   assign bus.forwardB      = fwd_b_q;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall),
      .count (bus.stall_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush),
      .count (bus.flush_count)
   );

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed vector table plus reset-mid-stall and counter saturation sequences.
module tb_hazard_forward_ctrl;
   import pipe_ctrl_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hazard_forward_ctrl_if #(.CNT_W(32)) bus ();
   hazard_forward_ctrl_if #(.CNT_W(2))  sbus ();

   hazard_forward_ctrl #(.CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   hazard_forward_ctrl #(.CNT_W(2)) dut_sat (
      .clk   (clk),
      .reset (reset),
      .bus   (sbus.slave)
   );

   assign sbus.id_valid     = bus.id_valid;
   assign sbus.id_rs1       = bus.id_rs1;
   assign sbus.id_rs2       = bus.id_rs2;
   assign sbus.id_rd        = bus.id_rd;
   assign sbus.id_regwrite  = bus.id_regwrite;
   assign sbus.id_memread   = bus.id_memread;
   assign sbus.branch_taken = bus.branch_taken;

   typedef struct {
      logic       v;
      int         rs1, rs2, rd;
      logic       rw, mr, br;
      logic       pcwe, bub, fl;
      logic [1:0] fa, fb;
      int         sc, fc;
   } vec_t;

   int total = 0;
   int bad   = 0;
   vec_t tbl[18];

   function automatic vec_t mk(input logic v, input int rs1, input int rs2, input int rd,
                               input logic rw, input logic mr, input logic br,
                               input logic pcwe, input logic bub, input logic fl,
                               input logic [1:0] fa, input logic [1:0] fb,
                               input int sc, input int fc);
      vec_t t;
      t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
      t.rw = rw; t.mr = mr; t.br = br;
      t.pcwe = pcwe; t.bub = bub; t.fl = fl;
      t.fa = fa; t.fb = fb; t.sc = sc; t.fc = fc;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      bus.id_valid     = t.v;
      bus.id_rs1       = REG_AW'(t.rs1);
      bus.id_rs2       = REG_AW'(t.rs2);
      bus.id_rd        = REG_AW'(t.rd);
      bus.id_regwrite  = t.rw;
      bus.id_memread   = t.mr;
      bus.branch_taken = t.br;
   endtask

   task automatic apply(input vec_t t, input string tag);
      @(negedge clk);
      drive(t);
      #1;
      chk({tag, " pc_write_en"},   64'(bus.pc_write_en),   64'(t.pcwe));
      chk({tag, " ifid_write_en"}, 64'(bus.ifid_write_en), 64'(t.pcwe));
      chk({tag, " idex_bubble"},   64'(bus.idex_bubble),   64'(t.bub));
      chk({tag, " flush_ifid"},    64'(bus.flush_ifid),    64'(t.fl));
      @(posedge clk);
      #1;
      chk({tag, " forwardA"},    64'(bus.forwardA),    64'(t.fa));
      chk({tag, " forwardB"},    64'(bus.forwardB),    64'(t.fb));
      chk({tag, " stall_count"}, 64'(bus.stall_count), 64'(t.sc));
      chk({tag, " flush_count"}, 64'(bus.flush_count), 64'(t.fc));
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, " pc_write_en"},   64'(bus.pc_write_en),   64'd1);
      chk({tag, " ifid_write_en"}, 64'(bus.ifid_write_en), 64'd1);
      chk({tag, " idex_bubble"},   64'(bus.idex_bubble),   64'd0);
      chk({tag, " flush_ifid"},    64'(bus.flush_ifid),    64'd0);
      chk({tag, " forwardA"},      64'(bus.forwardA),      64'd0);
      chk({tag, " forwardB"},      64'(bus.forwardB),      64'd0);
      chk({tag, " stall_count"},   64'(bus.stall_count),   64'd0);
      chk({tag, " flush_count"},   64'(bus.flush_count),   64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t ld5, use5, br_v;
      //            v  rs1 rs2 rd rw mr br  pcwe bub fl  fa     fb     sc fc
      tbl[0]  = mk(1, 1, 2, 5, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0); // add x5
      tbl[1]  = mk(1, 5, 1, 6, 1, 0, 0, 1, 0, 0, 2'b10, 2'b00, 0, 0); // add x6,x5,x1
      tbl[2]  = mk(1, 3, 4, 5, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0); // add x5
      tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0); // nop
      tbl[4]  = mk(1, 2, 5, 7, 1, 0, 0, 1, 0, 0, 2'b00, 2'b01, 0, 0); // sub x7,x2,x5
      tbl[5]  = mk(1, 1, 2, 0, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0); // add x0,x1,x2
      tbl[6]  = mk(1, 0, 0, 3, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0); // add x3,x0,x0
      tbl[7]  = mk(1, 1, 2, 5, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0); // add x5
      tbl[8]  = mk(1, 1, 2, 5, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0); // add x5
      tbl[9]  = mk(1, 5, 0, 6, 1, 0, 0, 1, 0, 0, 2'b10, 2'b00, 0, 0); // add x6,x5,x0
      tbl[10] = mk(1, 1, 0, 5, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0); // ld x5
      tbl[11] = mk(1, 5, 5, 6, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0); // add x6,x5,x5 stall
      tbl[12] = mk(1, 5, 5, 6, 1, 0, 0, 1, 0, 0, 2'b01, 2'b01, 1, 0); // held consumer
      tbl[13] = mk(1, 0, 0, 5, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1, 0); // ld x5
      tbl[14] = mk(1, 5, 1, 6, 1, 0, 1, 1, 1, 1, 2'b00, 2'b00, 1, 1); // consumer + branch
      tbl[15] = mk(1, 9, 9, 8, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 1, 1); // add x8,x9,x9
      tbl[16] = mk(1, 0, 0, 5, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1, 1); // ld x5
      tbl[17] = mk(0, 5, 5, 6, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 1, 1); // invalid reader

      reset = 1'b1;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0));
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("reset");
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 18; i++)
         apply(tbl[i], $sformatf("v%0d", i));

      // Reset while a load-use stall is being raised.
      apply(mk(1, 0, 0, 5, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1, 1), "pre_rst ld");
      @(negedge clk);
      drive(mk(1, 5, 5, 6, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0));
      reset = 1'b1;
      #1;
      chk("mid_rst stall visible", 64'(bus.pc_write_en), 64'd0);
      @(posedge clk);
      #1;
      chk_reset_state("mid_rst");
      @(negedge clk);
      reset = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0));

      // Five stalls then five flushes; the 2-bit instance must stick at 3.
      ld5  = mk(1, 0, 0, 5, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0);
      use5 = mk(1, 5, 5, 6, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0);
      for (int i = 0; i < 5; i++) begin
         ld5.sc  = i;
         use5.sc = i + 1;
         apply(ld5,  $sformatf("sat ld%0d", i));
         apply(use5, $sformatf("sat use%0d", i));
         chk($sformatf("sat small stall_count %0d", i), 64'(sbus.stall_count),
             64'((i + 1 > 3) ? 3 : i + 1));
      end
      br_v = mk(1, 9, 9, 8, 1, 0, 1, 1, 1, 1, 2'b00, 2'b00, 5, 0);
      for (int i = 0; i < 5; i++) begin
         br_v.fc = i + 1;
         apply(br_v, $sformatf("sat br%0d", i));
         chk($sformatf("sat small flush_count %0d", i), 64'(sbus.flush_count),
             64'((i + 1 > 3) ? 3 : i + 1));
         chk($sformatf("sat small stall_count hold %0d", i), 64'(sbus.stall_count), 64'd3);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
